rename_map: RTL and testbench

- Register-rename stage that sits directly downstream of the free-tag ring buffer.
- Each accepted instruction with a real destination pops one physical tag from the ring buffer's output.
- Its architectural operands are translated through a speculative map table.
- A committed map table, updated by the retire path, restores the speculative map on flush.

---
 rtl/rename_map.sv | 87 ++++++++
 tb/tb_rename_map.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rename_map.sv
// rename_map: register rename stage with speculative and committed map tables
module rename_map #(
    parameter int TAG_W = 6,
    parameter int AREGS = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [4:0]       i_rs1,
    input  logic [4:0]       i_rs2,
    input  logic [4:0]       i_rd,
    input  logic             i_rd_we,
    input  logic [TAG_W-1:0] i_fl_data,
    input  logic             i_fl_empty,
    output logic             o_fl_re,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [TAG_W-1:0] o_prs1,
    output logic [TAG_W-1:0] o_prs2,
    output logic [TAG_W-1:0] o_prd,
    output logic [TAG_W-1:0] o_pold,
    output logic             o_rd_we,
    input  logic             i_cmt_valid,
    input  logic [4:0]       i_cmt_rd,
    input  logic [TAG_W-1:0] i_cmt_prd,
    input  logic             i_flush
);
    logic [TAG_W-1:0] spec_map [AREGS];
    logic [TAG_W-1:0] cmt_map  [AREGS];
    logic [TAG_W-1:0] cmt_nx   [AREGS];
    logic             need_tag;
    logic             accept;

    assign need_tag = i_rd_we & (i_rd != 5'd0);
    assign o_ready  = ~i_flush & (~o_valid | i_ready) & (~need_tag | ~i_fl_empty);
    assign accept   = i_valid & o_ready;
    assign o_fl_re  = accept & need_tag;

    // committed map including this cycle's retire write, also the flush restore source
    always_comb begin
        for (int a = 0; a < AREGS; a++)
            cmt_nx[a] = (i_cmt_valid && i_cmt_rd != 5'd0 && i_cmt_rd == 5'(a)) ? i_cmt_prd : cmt_map[a];
    end

    // map tables: retire updates every cycle, flush restores, accepted writers rename rd
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int a = 0; a < AREGS; a++) begin
                spec_map[a] <= TAG_W'(a);
                cmt_map[a]  <= TAG_W'(a);
            end
        end else begin
            for (int a = 0; a < AREGS; a++)
                cmt_map[a] <= cmt_nx[a];
            if (i_flush) begin
                for (int a = 0; a < AREGS; a++)
                    spec_map[a] <= cmt_nx[a];
            end else if (o_fl_re) begin
                spec_map[i_rd] <= i_fl_data;
            end
        end
    end

    // output register: load on accept, drop on flush or downstream take
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_prs1  <= '0;
            o_prs2  <= '0;
            o_prd   <= '0;
            o_pold  <= '0;
            o_rd_we <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (accept) begin
            o_valid <= 1'b1;
            o_prs1  <= spec_map[i_rs1];
            o_prs2  <= spec_map[i_rs2];
            o_pold  <= spec_map[i_rd];
            o_prd   <= need_tag ? i_fl_data : '0;
            o_rd_we <= need_tag;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rename_map.sv
// tb_rename_map: random and directed scoreboard bench for rename_map
module tb_rename_map;
    localparam int TAG_W = 6;
    typedef logic [4*TAG_W:0] out_t;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [4:0]       i_rs1 = '0;
    logic [4:0]       i_rs2 = '0;
    logic [4:0]       i_rd = '0;
    logic             i_rd_we = 1'b0;
    logic [TAG_W-1:0] i_fl_data = '0;
    logic             i_fl_empty = 1'b0;
    logic             o_fl_re;
    logic             o_valid;
    logic             i_ready = 1'b1;
    logic [TAG_W-1:0] o_prs1;
    logic [TAG_W-1:0] o_prs2;
    logic [TAG_W-1:0] o_prd;
    logic [TAG_W-1:0] o_pold;
    logic             o_rd_we;
    logic             i_cmt_valid = 1'b0;
    logic [4:0]       i_cmt_rd = '0;
    logic [TAG_W-1:0] i_cmt_prd = '0;
    logic             i_flush = 1'b0;

    rename_map #(.TAG_W(TAG_W), .AREGS(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_rd_we(i_rd_we),
        .i_fl_data(i_fl_data), .i_fl_empty(i_fl_empty), .o_fl_re(o_fl_re),
        .o_valid(o_valid), .i_ready(i_ready), .o_prs1(o_prs1), .o_prs2(o_prs2),
        .o_prd(o_prd), .o_pold(o_pold), .o_rd_we(o_rd_we),
        .i_cmt_valid(i_cmt_valid), .i_cmt_rd(i_cmt_rd), .i_cmt_prd(i_cmt_prd),
        .i_flush(i_flush)
    );

    always #5 i_clk = ~i_clk;

    int   n_vec = 0;
    int   n_err = 0;
    out_t sb[$];
    out_t mon_e;
    int   m_spec[32];
    int   m_cmt[32];
    bit   exp_valid = 1'b0;

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic out_t pack(int a, int b, int c, int d, bit w);
        return {TAG_W'(a), TAG_W'(b), TAG_W'(c), TAG_W'(d), w};
    endfunction

    // monitor: every transfer to downstream is checked against the oldest expectation
    always @(negedge i_clk) begin
        if (i_rst_n && o_valid && i_ready && !i_flush) begin
            if (sb.size() == 0) begin
                chk("spurious_out", int'(o_valid), 0);
            end else begin
                mon_e = sb.pop_front();
                n_vec++;
                if ({o_prs1, o_prs2, o_prd, o_pold, o_rd_we} != mon_e) begin
                    n_err++;
                    $display("FAIL out: got prs1=%0d prs2=%0d prd=%0d pold=%0d we=%0d expected %h",
                             o_prs1, o_prs2, o_prd, o_pold, o_rd_we, mon_e);
                end
            end
        end
    end

    // reference model: evaluates the rename rules on current inputs, then advances one edge
    task automatic step();
        bit need, rdy, acc;
        #1;
        need = i_rd_we && (i_rd != 5'd0);
        rdy  = !i_flush && (!exp_valid || i_ready) && (!need || !i_fl_empty);
        acc  = i_valid && rdy;
        chk("o_valid", int'(o_valid), int'(exp_valid));
        chk("o_ready", int'(o_ready), int'(rdy));
        chk("o_fl_re", int'(o_fl_re), int'(acc && need));
        if (i_cmt_valid && i_cmt_rd != 5'd0) m_cmt[i_cmt_rd] = int'(i_cmt_prd);
        if (i_flush) begin
            m_spec = m_cmt;
            exp_valid = 1'b0;
            sb.delete();
        end else if (acc) begin
            sb.push_back(pack(m_spec[i_rs1], m_spec[i_rs2], need ? int'(i_fl_data) : 0, m_spec[i_rd], need));
            if (need) m_spec[i_rd] = int'(i_fl_data);
            exp_valid = 1'b1;
        end else if (i_ready) begin
            exp_valid = 1'b0;
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic ins(int rs1, int rs2, int rd, bit we, int fl);
        i_valid   = 1'b1;
        i_rs1     = 5'(rs1);
        i_rs2     = 5'(rs2);
        i_rd      = 5'(rd);
        i_rd_we   = we;
        i_fl_data = TAG_W'(fl);
        step();
    endtask

    initial begin
        for (int a = 0; a < 32; a++) begin
            m_spec[a] = a;
            m_cmt[a]  = a;
        end
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_prs1", int'(o_prs1), 0);
        chk("rst_prs2", int'(o_prs2), 0);
        chk("rst_prd", int'(o_prd), 0);
        chk("rst_pold", int'(o_pold), 0);
        chk("rst_rd_we", int'(o_rd_we), 0);
        i_rst_n = 1'b1;
        ins(5, 7, 3, 1, 32);
        ins(3, 0, 3, 1, 33);
        ins(0, 0, 0, 1, 50);
        ins(0, 1, 2, 0, 51);
        i_fl_empty = 1'b1;
        ins(1, 2, 4, 1, 40);
        ins(1, 2, 4, 1, 40);
        ins(1, 2, 0, 0, 40);
        i_fl_empty = 1'b0;
        ins(1, 2, 4, 1, 40);
        ins(6, 7, 8, 1, 41);
        i_ready = 1'b0;
        repeat (3) ins(9, 10, 11, 1, 42);
        i_ready = 1'b1;
        ins(9, 10, 11, 1, 42);
        ins(0, 0, 3, 1, 32);
        ins(0, 0, 3, 1, 33);
        i_valid = 1'b0;
        i_flush = 1'b1;
        i_cmt_valid = 1'b1;
        i_cmt_rd = 5'd3;
        i_cmt_prd = TAG_W'(32);
        step();
        i_flush = 1'b0;
        i_cmt_valid = 1'b0;
        ins(3, 0, 0, 0, 0);
        ins(0, 0, 5, 1, 44);
        for (int i = 0; i < 800; i++) begin
            i_valid     = ($urandom_range(0, 3) != 0);
            i_rs1       = 5'($urandom_range(0, 31));
            i_rs2       = 5'($urandom_range(0, 31));
            i_rd        = 5'($urandom_range(0, 31));
            i_rd_we     = ($urandom_range(0, 3) != 0);
            i_fl_data   = TAG_W'($urandom_range(0, 63));
            i_fl_empty  = ($urandom_range(0, 4) == 0);
            i_ready     = ($urandom_range(0, 3) != 0);
            i_flush     = ($urandom_range(0, 19) == 0);
            i_cmt_valid = ($urandom_range(0, 1) != 0);
            i_cmt_rd    = 5'($urandom_range(0, 31));
            i_cmt_prd   = TAG_W'($urandom_range(0, 63));
            step();
        end
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_cmt_valid = 1'b0;
        i_ready = 1'b1;
        repeat (3) step();
        chk("drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
